// File: rtl/rle_pkg.sv
// Shared definitions for the RLE codec blocks: row geometry, code-byte layout
// and scan FSM state encoding.
package rle_pkg;

    localparam int unsigned ROW_W   = 256;
    localparam int unsigned RUN_MAX = 127;

    typedef struct packed {
        logic       val;
        logic [6:0] run;
    } rle_code_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

endpackage

// File: rtl/rle_out_reg.sv
// Single-entry valid/ready holding register for RLE code bytes; tells the
// scan FSM when a new code may be loaded.
module rle_out_reg
    import rle_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  rle_code_t  i_code,
    input  logic       i_last,
    input  logic       i_out_ready,
    output logic [7:0] o_out_byte,
    output logic       o_out_valid,
    output logic       o_out_last,
    output logic       o_load_ok
);

    logic [7:0] r_byte;
    logic       r_valid;
    logic       r_last;

    assign o_load_ok   = !r_valid || i_out_ready;
    assign o_out_byte  = r_byte;
    assign o_out_valid = r_valid;
    assign o_out_last  = r_last;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_byte  <= 8'd0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_byte  <= {i_code.val, i_code.run};
            r_valid <= 1'b1;
            r_last  <= i_last;
        end else if (i_out_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rle_compress.sv
// Run-length encoder: one 256-bit row in, MSB-first code bytes {val, run} out.
// Optional RLE_CNT_EN adds o_code_cnt, the code count of the most recent row.
//   state | meaning
//   IDLE  | ready for a row
//   SCAN  | consuming one row bit per unstalled cycle
//   FLUSH | loading the final (last-flagged) code
//   DRAIN | waiting for the final code to be taken
module rle_compress
    import rle_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [ROW_W-1:0] i_din,
    input  logic             i_din_valid,
    output logic             o_din_ready,
    output logic [7:0]       o_out_byte,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_out_last,
`ifdef RLE_CNT_EN
    output logic [8:0]       o_code_cnt,
`endif
    output logic             o_done
);

    logic [1:0]       r_state;
    logic [ROW_W-1:0] r_sr;
    logic             r_cur_val;
    logic [6:0]       r_run;
    logic [7:0]       r_bit_cnt;
    logic             r_done;

    logic      w_bit;
    logic      w_emit;
    logic      w_load;
    logic      w_last;
    logic      w_load_ok;
    logic      w_scan_adv;
    logic      w_row_acc;
    logic      w_row_end;
    rle_code_t w_code;

    assign w_bit       = r_sr[ROW_W-1];
    assign w_row_acc   = (r_state == ST_IDLE) && i_din_valid;
    assign w_row_end   = (r_state == ST_DRAIN) && o_out_valid && i_out_ready && o_out_last;
    assign o_din_ready = (r_state == ST_IDLE);
    assign o_done      = r_done;

    always_comb begin
        w_emit     = (r_state == ST_SCAN) && ((w_bit != r_cur_val) || (r_run == 7'(RUN_MAX)));
        w_load     = 1'b0;
        w_last     = 1'b0;
        w_code.val = r_cur_val;
        w_code.run = r_run;
        if (r_state == ST_SCAN) begin
            w_load = w_emit && w_load_ok;
        end else if (r_state == ST_FLUSH) begin
            w_load = w_load_ok;
            w_last = 1'b1;
        end
    end

    // A pending emit that cannot be loaded freezes the whole scan datapath.
    assign w_scan_adv = (r_state == ST_SCAN) && (!w_emit || w_load_ok);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_sr      <= '0;
            r_cur_val <= 1'b0;
            r_run     <= 7'd0;
            r_bit_cnt <= 8'd0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_row_acc) begin
                        r_sr      <= i_din;
                        r_cur_val <= i_din[ROW_W-1];
                        r_run     <= 7'd0;
                        r_bit_cnt <= 8'd0;
                        r_state   <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (w_scan_adv) begin
                        r_sr      <= {r_sr[ROW_W-2:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt + 8'd1;
                        if (w_emit) begin
                            r_cur_val <= w_bit;
                            r_run     <= 7'd1;
                        end else begin
                            r_run <= r_run + 7'd1;
                        end
                        if (r_bit_cnt == 8'(ROW_W - 1)) begin
                            r_state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (w_load_ok) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_row_end) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef RLE_CNT_EN
    logic [8:0] r_cnt;
    logic [8:0] r_code_cnt;

    assign o_code_cnt = r_code_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt      <= 9'd0;
            r_code_cnt <= 9'd0;
        end else begin
            if (w_row_acc) begin
                r_cnt <= 9'd0;
            end else if (w_load) begin
                r_cnt <= r_cnt + 9'd1;
            end
            if (w_row_end) begin
                r_code_cnt <= r_cnt;
            end
        end
    end
`endif

    rle_out_reg u_out_reg (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (w_load),
        .i_code      (w_code),
        .i_last      (w_last),
        .i_out_ready (i_out_ready),
        .o_out_byte  (o_out_byte),
        .o_out_valid (o_out_valid),
        .o_out_last  (o_out_last),
        .o_load_ok   (w_load_ok)
    );

endmodule
